// File: rtl/snek_pkg.sv
// -----------------------------------------------------------------------------
// snek_pkg
// Shared types and constants for the snake movement engine.
//   dir_t         : movement direction (up/right/down/left)
//   moveState_t   : states of the move engine FSM
//   MV_*          : 2-bit movement result codes decoded by the main game FSM
//   DEF_*         : default playfield and body-buffer dimensions
//   oppositeDir() : direction that would reverse the snake onto itself
// -----------------------------------------------------------------------------
package snek_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_SCAN,
    S_COMMIT,
    S_REPORT,
    S_HOLD
  } moveState_t;

  localparam logic [1:0] MV_BUSY = 2'b00;
  localparam logic [1:0] MV_OK   = 2'b01;
  localparam logic [1:0] MV_EAT  = 2'b10;
  localparam logic [1:0] MV_LOSE = 2'b11;

  localparam int DEF_GRID_W   = 32;
  localparam int DEF_GRID_H   = 24;
  localparam int DEF_MAX_LEN  = 64;
  localparam int DEF_INIT_LEN = 3;

  // The encoding pairs opposites two apart, so flipping bit 1 reverses.
  function automatic dir_t oppositeDir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_body_buf.sv
// -----------------------------------------------------------------------------
// snake_body_buf
// Circular buffer of snake body cells, one (x,y) entry per segment.
// Ports:
//   clk              : clock
//   wrEn             : write strobe
//   wrIdx, wrX, wrY  : write slot and cell coordinates
//   rdIdx            : read slot (combinational read)
//   rdX, rdY         : cell stored at rdIdx
// -----------------------------------------------------------------------------
module snake_body_buf #(
  parameter int MAX_LEN = 64,
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int PTR_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [PTR_W-1:0] wrIdx,
  input  logic [X_W-1:0]   wrX,
  input  logic [Y_W-1:0]   wrY,
  input  logic [PTR_W-1:0] rdIdx,
  output logic [X_W-1:0]   rdX,
  output logic [Y_W-1:0]   rdY
);

  logic [X_W-1:0] memX [MAX_LEN];
  logic [Y_W-1:0] memY [MAX_LEN];

  // NOTE: the storage array has no reset; only slots between the tail and
  // head pointers are ever read, and those are always written first.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      memX[wrIdx] <= wrX;
      memY[wrIdx] <= wrY;
    end
  end

  assign rdX = memX[rdIdx];
  assign rdY = memY[rdIdx];

endmodule

// File: rtl/snake_move_engine.sv
// -----------------------------------------------------------------------------
// snake_move_engine
// Answers the main game FSM's setup and move requests. Setup lays down the
// initial body; a move advances the head one cell, checks walls, food and
// self-collision, commits the body update and returns a 2-bit result.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   setUpGo, moveGo         : level requests from the main FSM
//   dirIn, dirValid         : requested direction and its one-cycle strobe
//   foodX, foodY            : food cell
//   setUpDone               : body initialised, held while setUpGo stays high
//   movementLogic           : 00 busy, 01 moved, 10 ate, 11 lose (one cycle)
//   headX, headY, length    : current head cell and body length
//   tailEraseValid/X/Y      : one-cycle pulse naming the vacated tail cell
// Build option:
//   SNEK_WRAP_EN defined    : the playfield wraps; only self-collision loses
//   SNEK_WRAP_EN undefined  : leaving the playfield loses
// -----------------------------------------------------------------------------
module snake_move_engine
  import snek_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int INIT_LEN = DEF_INIT_LEN,
  localparam int X_W     = $clog2(GRID_W),
  localparam int Y_W     = $clog2(GRID_H),
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int PTR_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             setUpGo,
  input  logic             moveGo,
  input  logic [1:0]       dirIn,
  input  logic             dirValid,
  input  logic [X_W-1:0]   foodX,
  input  logic [Y_W-1:0]   foodY,
  output logic             setUpDone,
  output logic [1:0]       movementLogic,
  output logic [X_W-1:0]   headX,
  output logic [Y_W-1:0]   headY,
  output logic [LEN_W-1:0] length,
  output logic             tailEraseValid,
  output logic [X_W-1:0]   tailEraseX,
  output logic [Y_W-1:0]   tailEraseY
);

  // Initial body runs horizontally, tail on the left, head at the centre.
  localparam int INIT_TAIL_X = GRID_W / 2 - INIT_LEN + 1;

  moveState_t state, nextState;

  dir_t             curDir, pendingDir;
  logic [PTR_W-1:0] headPtr, tailPtr, scanPtr;
  logic [LEN_W-1:0] initCnt, scanLeft;
  logic [X_W-1:0]   nextX;
  logic [Y_W-1:0]   nextY;
  logic             eat;
  logic [1:0]       result;

  // Combinational helpers
  logic [X_W-1:0]   calcX;
  logic [Y_W-1:0]   calcY;
  logic             edgeHit, wallHit, calcEat, segHit, initWr;
  logic [LEN_W-1:0] calcScanCnt;
  logic             wrEn;
  logic [PTR_W-1:0] wrIdx, rdIdx;
  logic [X_W-1:0]   wrX, rdX;
  logic [Y_W-1:0]   wrY, rdY;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (int'(p) == MAX_LEN - 1) ? '0 : p + 1'b1;
  endfunction

  // Candidate head cell. Coordinates wrap here; whether crossing an edge is
  // fatal is decided separately below.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    calcX   = headX;
    calcY   = headY;
    edgeHit = 1'b0;
    unique case (curDir)
      DIR_UP: begin
        edgeHit = (headY == '0);
        calcY   = edgeHit ? Y_W'(GRID_H - 1) : headY - 1'b1;
      end
      DIR_RIGHT: begin
        edgeHit = (headX == X_W'(GRID_W - 1));
        calcX   = edgeHit ? '0 : headX + 1'b1;
      end
      DIR_DOWN: begin
        edgeHit = (headY == Y_W'(GRID_H - 1));
        calcY   = edgeHit ? '0 : headY + 1'b1;
      end
      DIR_LEFT: begin
        edgeHit = (headX == '0);
        calcX   = edgeHit ? X_W'(GRID_W - 1) : headX - 1'b1;
      end
    endcase
  end

`ifdef SNEK_WRAP_EN
  assign wallHit = 1'b0;
`else
  assign wallHit = edgeHit;
`endif

  assign calcEat = (calcX == foodX) && (calcY == foodY);
  // The tail cell is skipped when not eating because it vacates this move.
  assign calcScanCnt = calcEat ? length :
                       (length == '0) ? '0 : length - 1'b1;

  assign initWr = (state == S_INIT) && setUpGo && (initCnt < LEN_W'(INIT_LEN));
  assign segHit = (rdX == nextX) && (rdY == nextY);

  // One read port: walks the body during SCAN, otherwise sits on the tail so
  // COMMIT can report the cell it vacates.
  assign rdIdx = (state == S_SCAN) ? scanPtr : tailPtr;

  always_comb begin
    wrEn  = initWr || (state == S_COMMIT);
    wrIdx = ptrInc(headPtr);
    wrX   = nextX;
    wrY   = nextY;
    if (state == S_INIT) begin
      wrIdx = PTR_W'(initCnt);
      wrX   = X_W'(INIT_TAIL_X) + X_W'(initCnt);
      wrY   = Y_W'(GRID_H / 2);
    end
  end

  snake_body_buf #(
    .MAX_LEN (MAX_LEN),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .PTR_W   (PTR_W)
  ) u_body (
    .clk   (clk),
    .wrEn  (wrEn),
    .wrIdx (wrIdx),
    .wrX   (wrX),
    .wrY   (wrY),
    .rdIdx (rdIdx),
    .rdX   (rdX),
    .rdY   (rdY)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState     = state;
    movementLogic = MV_BUSY;
    unique case (state)
      S_IDLE: begin
        if (setUpGo)     nextState = S_INIT;
        else if (moveGo) nextState = S_CALC;
      end
      S_INIT: begin
        if (!setUpGo) nextState = S_IDLE;
      end
      S_CALC: begin
        if (!moveGo)                nextState = S_IDLE;
        else if (wallHit)           nextState = S_REPORT;
        else if (calcScanCnt == '0) nextState = S_COMMIT;
        else                        nextState = S_SCAN;
      end
      S_SCAN: begin
        if (!moveGo)                     nextState = S_IDLE;
        else if (segHit)                 nextState = S_REPORT;
        else if (scanLeft == LEN_W'(1))  nextState = S_COMMIT;
      end
      S_COMMIT: nextState = S_REPORT;
      S_REPORT: begin
        movementLogic = result;
        nextState     = S_HOLD;
      end
      S_HOLD: begin
        if (!moveGo) nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      curDir         <= DIR_RIGHT;
      pendingDir     <= DIR_RIGHT;
      headPtr        <= '0;
      tailPtr        <= '0;
      scanPtr        <= '0;
      initCnt        <= '0;
      scanLeft       <= '0;
      nextX          <= '0;
      nextY          <= '0;
      eat            <= 1'b0;
      result         <= MV_BUSY;
      setUpDone      <= 1'b0;
      headX          <= '0;
      headY          <= '0;
      length         <= '0;
      tailEraseValid <= 1'b0;
      tailEraseX     <= '0;
      tailEraseY     <= '0;
    end else begin
      tailEraseValid <= 1'b0;

      // Reversal is judged against the direction actually being travelled.
      if (dirValid && (dir_t'(dirIn) != oppositeDir(curDir)))
        pendingDir <= dir_t'(dirIn);

      unique case (state)
        S_IDLE: begin
          initCnt <= '0;
          if (nextState == S_CALC) curDir <= pendingDir;
        end
        S_INIT: begin
          if (!setUpGo) begin
            setUpDone <= 1'b0;
          end else if (initWr) begin
            initCnt <= initCnt + 1'b1;
            if (initCnt == LEN_W'(INIT_LEN - 1)) begin
              setUpDone  <= 1'b1;
              length     <= LEN_W'(INIT_LEN);
              headX      <= X_W'(GRID_W / 2);
              headY      <= Y_W'(GRID_H / 2);
              tailPtr    <= '0;
              headPtr    <= PTR_W'(INIT_LEN - 1);
              curDir     <= DIR_RIGHT;
              pendingDir <= DIR_RIGHT;
            end
          end
        end
        S_CALC: begin
          nextX    <= calcX;
          nextY    <= calcY;
          eat      <= calcEat;
          scanPtr  <= tailPtr;
          scanLeft <= calcScanCnt;
          if (wallHit) result <= MV_LOSE;
        end
        S_SCAN: begin
          scanPtr  <= ptrInc(scanPtr);
          scanLeft <= scanLeft - 1'b1;
          if (segHit) result <= MV_LOSE;
        end
        S_COMMIT: begin
          headPtr <= ptrInc(headPtr);
          headX   <= nextX;
          headY   <= nextY;
          if (eat && (length < LEN_W'(MAX_LEN))) begin
            length <= length + 1'b1;
            result <= MV_EAT;
          end else begin
            // A full-length snake that eats still advances like a plain move.
            tailPtr        <= ptrInc(tailPtr);
            tailEraseValid <= 1'b1;
            tailEraseX     <= rdX;
            tailEraseY     <= rdY;
            result         <= eat ? MV_EAT : MV_OK;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/snake_move_engine.md
Name: snake_move_engine

Overview:
- Responder to the main game FSM's move request. On setUpGo it initialises the snake body. On moveGo it advances the head one cell, checks walls, food and self-collision, and commits the body update.
- Returns the 2-bit movement result code that the main FSM decodes: 00 busy, 01 moved, 10 ate, 11 lose.
- Owns the snake body circular buffer and exports head/tail coordinates for the renderer.

Parameters:
- GRID_W, 32, playfield width in cells
- GRID_H, 24, playfield height in cells
- MAX_LEN, 64, body buffer depth (maximum snake length)
- INIT_LEN, 3, length after setup (2 <= INIT_LEN <= MAX_LEN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- setUpGo  in  1  level; main FSM is in setUp
- moveGo  in  1  level; main FSM is in move
- dirIn  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- dirValid  in  1  one-cycle strobe qualifying dirIn
- foodX  in  $clog2(GRID_W)  food column
- foodY  in  $clog2(GRID_H)  food row
- setUpDone  out  1  initialisation complete
- movementLogic  out  2  result code; 00 while busy or idle
- headX, headY  out  X_W/Y_W  current head cell
- length  out  $clog2(MAX_LEN+1)  current body length
- tailEraseValid  out  1  one-cycle pulse: cell at tailErase must be cleared
- tailEraseX, tailEraseY  out  X_W/Y_W  vacated tail cell

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values: all outputs 0; length 0; head/tail pointers 0; current and pending direction = right (01); FSM = IDLE.
- Direction latch: on dirValid, pendingDir <= dirIn, unless dirIn is the opposite of curDir, in which case it is ignored. Latching happens in any state. curDir <= pendingDir at the start of each move (IDLE->CALC).
- FSM states: IDLE, INIT, CALC, SCAN, COMMIT, REPORT, HOLD.
- IDLE:
  - setUpGo=1 -> INIT.
  - Else moveGo=1 -> CALC.
  - setUpGo has priority if both are high.
- INIT:
  - Writes INIT_LEN segments, one per cycle.
  - Tail at (GRID_W/2-INIT_LEN+1, GRID_H/2); head at (GRID_W/2, GRID_H/2).
  - Sets length=INIT_LEN, curDir=pendingDir=right.
  - Then setUpDone=1 from the following cycle, held while setUpGo=1. setUpGo=0 -> setUpDone=0, go to IDLE.
- CALC (1 cycle):
  - nextHead = head + delta(curDir); y increases downward.
  - Out of bounds (x<0, x>=GRID_W, y<0, y>=GRID_H) -> result 11, go to REPORT.
  - Else eat = (nextHead == food); scanCnt = eat ? length : length-1. The tail is excluded when not eating, because it vacates.
- SCAN:
  - One segment compared per cycle, from the tail upward.
  - Any match with nextHead -> result 11, go to REPORT.
  - After scanCnt compares with no match -> COMMIT.
- COMMIT (1 cycle):
  - Write nextHead at headPtr+1 (mod MAX_LEN); update headX/headY.
  - Not eating: tail pointer advances; tailEraseValid pulses with the old tail coordinates; result 01.
  - Eating with length<MAX_LEN: length+1, tail stays, no erase pulse; result 10.
  - Eating with length==MAX_LEN: treated as a normal advance (tail advances, erase pulse) but result is still 10.
- REPORT: movementLogic = result for exactly 1 cycle, then HOLD.
- HOLD: movementLogic=00; wait for moveGo=0, then IDLE. A single move request never produces two results.
- Abort: moveGo dropping in CALC or SCAN -> IDLE with no commit and no result. setUpGo dropping in INIT -> IDLE, setUpDone stays 0.
- Latency, moveGo high to result: 2 + scanCnt + (commit ? 1 : 0) cycles. A wall hit reports in 2 cycles.
- Pointer arithmetic is modulo MAX_LEN; pointer widths are $clog2(MAX_LEN).
- reset overrides everything, in any state.

Optional Feature:
- Macro: SNEK_WRAP_EN.
- Defined: no wall loss. nextHead wraps modulo GRID_W/GRID_H, e.g. x=GRID_W-1 moving right becomes x=0. Only self-collision yields 11.
- Undefined: out-of-bounds -> 11, as above.

Decomposition:
- Package snek_pkg:
  - dir_t enum (DIR_UP/RIGHT/DOWN/LEFT)
  - result codes MV_BUSY=2'b00, MV_OK=2'b01, MV_EAT=2'b10, MV_LOSE=2'b11
  - default grid constants
  - opposite-direction function
- Sub-module snake_body_buf:
  - MAX_LEN-entry circular buffer holding (x,y).
  - Ports: one write port (wrEn, wrIdx, wrX, wrY) and one combinational read port (rdIdx -> rdX, rdY), used by both SCAN and tail erase.

Test Plan:
- Reset then setUpGo high for 10 cycles (32x24, INIT_LEN=3) -> setUpDone=1 by cycle 5; head=(16,12); tail=(14,12); length=3.
- moveGo with dir right, food at (0,0) -> result 01 after 2+2+1 cycles; head=(17,12); tailEraseValid pulse at (14,12); length=3.
- Food at (17,12), moveGo -> result 10; length=4; no erase pulse.
- Head at (31,5) moving right: without SNEK_WRAP_EN -> 11 two cycles after moveGo. With SNEK_WRAP_EN -> head=(0,5), result 01.
- Length 5; inputs up, left, down applied as successive moves -> 11 on the third move (self-hit). Also: dirIn=left while moving right -> ignored.
- moveGo held 20 cycles after the result -> exactly one nonzero movementLogic cycle. Reset asserted mid-SCAN -> all outputs 0 next cycle.
